// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - writeback port arbiter: fixed priority with aging promotion, speculation aware
module wb_port_arbiter #(
    parameter int N_REQ      = 3,
    parameter int SEL_W      = 5,
    parameter int STARVE_MAX = 7
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_spec,
    input  logic [N_REQ*SEL_W-1:0]   req_sel,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     flush,
    input  logic                     resolved,
    output logic                     wb_write,
    output logic [SEL_W-1:0]         wb_sel,
    output logic [$clog2(N_REQ)-1:0] wb_src,
    output logic                     wb_spec
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    logic [AGE_W-1:0] age_q [N_REQ];
    logic [AGE_W-1:0] age_d [N_REQ];
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             wb_write_q, wb_write_d;
    logic [SEL_W-1:0] wb_sel_q, wb_sel_d;
    logic [IDX_W-1:0] wb_src_q, wb_src_d;
    logic             wb_spec_q, wb_spec_d;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] starved;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        elig     = req_valid & ~(req_spec & {N_REQ{flush}});
        starved  = '0;
        found    = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            starved[i] = elig[i] && (age_q[i] == AGE_MAX);
        end
        if (|starved) begin
            // Walk the starved set starting at the round-robin pointer.
            for (int k = 0; k < N_REQ; k++) begin
                cand_sum = {1'b0, rr_q} + (IDX_W+1)'(k);
                if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
                    cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
                end
                cand = cand_sum[IDX_W-1:0];
                if (!found && starved[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    found   = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
        grant = '0;
        if (found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if ((|starved) && found) begin
            rr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i] || !elig[i] || flush) begin
                age_d[i] = '0;
            end else if (age_q[i] == AGE_MAX) begin
                age_d[i] = AGE_MAX;
            end else begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end

        wb_write_d = found;
        wb_sel_d   = wb_sel_q;
        wb_src_d   = wb_src_q;
        wb_spec_d  = wb_spec_q & ~resolved & ~flush;
        if (found) begin
            wb_src_d  = gnt_idx;
            wb_spec_d = req_spec[gnt_idx] & ~resolved;
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_idx == IDX_W'(i)) begin
                    wb_sel_d = req_sel[i*SEL_W +: SEL_W];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            rr_q       <= '0;
            wb_write_q <= 1'b0;
            wb_sel_q   <= '0;
            wb_src_q   <= '0;
            wb_spec_q  <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            wb_write_q <= wb_write_d;
            wb_sel_q   <= wb_sel_d;
            wb_src_q   <= wb_src_d;
            wb_spec_q  <= wb_spec_d;
            for (int i = 0; i < N_REQ; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // A speculative writeback being presented while flush is high is squashed.
    assign req_ready = rst ? '0 : grant;
    assign wb_write  = wb_write_q & ~(flush & wb_spec_q);
    assign wb_sel    = wb_sel_q;
    assign wb_src    = wb_src_q;
    assign wb_spec   = wb_spec_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed and randomized checks of wb_port_arbiter against a reference model
module tb_wb_port_arbiter;

    localparam int N    = 3;
    localparam int SW   = 5;
    localparam int SMAX = 7;

    logic            CLK;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_spec;
    logic [N*SW-1:0] req_sel;
    logic [N-1:0]    req_ready;
    logic            flush;
    logic            resolved;
    logic            wb_write;
    logic [SW-1:0]   wb_sel;
    logic [1:0]      wb_src;
    logic            wb_spec;

    wb_port_arbiter #(.N_REQ(N), .SEL_W(SW), .STARVE_MAX(SMAX)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .req_valid (req_valid),
        .req_spec  (req_spec),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .flush     (flush),
        .resolved  (resolved),
        .wb_write  (wb_write),
        .wb_sel    (wb_sel),
        .wb_src    (wb_src),
        .wb_spec   (wb_spec)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_age [N];
    int m_rr;
    bit m_wr;
    bit m_spec;
    int m_sel;
    int m_src;
    logic [N-1:0] last_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Starved requesters win, nearest at-or-after the RR pointer; else lowest index.
    function automatic int pick(input logic [N-1:0] e, output bit via_starve);
        int best = -1;
        int best_dist = N;
        via_starve = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (e[i] && m_age[i] == SMAX && ((i - m_rr + N) % N) < best_dist) begin
                best_dist = (i - m_rr + N) % N;
                best = i;
            end
        end
        if (best >= 0) begin
            via_starve = 1'b1;
            return best;
        end
        for (int i = 0; i < N; i++) begin
            if (e[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_cycle(input int exp_rdy, input int exp_wr);
        logic [N-1:0] elig;
        logic [N-1:0] er;
        int g;
        bit vs;
        #1;
        elig = rst ? '0 : (req_valid & ~(flush ? req_spec : '0));
        g = pick(elig, vs);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("ready", 32'(req_ready), 32'(er));
        check("wb_write", 32'(wb_write), 32'(m_wr & !(flush && m_spec)));
        check("wb_sel", 32'(wb_sel), m_sel);
        check("wb_src", 32'(wb_src), m_src);
        if (m_wr) check("wb_spec", 32'(wb_spec), 32'(m_spec));
        if (exp_rdy >= 0) check("dir_ready", 32'(req_ready), exp_rdy);
        if (exp_wr >= 0) check("dir_wb_write", 32'(wb_write), exp_wr);
        last_ready = req_ready;
        if (rst) begin
            for (int i = 0; i < N; i++) m_age[i] = 0;
            m_rr = 0; m_wr = 0; m_spec = 0; m_sel = 0; m_src = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (g == i || !elig[i] || flush) m_age[i] = 0;
                else if (m_age[i] < SMAX) m_age[i] = m_age[i] + 1;
            end
            if (vs) m_rr = (g + 1) % N;
            if (g >= 0) begin
                m_wr   = 1;
                m_sel  = int'(req_sel[g*SW +: SW]);
                m_src  = g;
                m_spec = req_spec[g] && !resolved;
            end else begin
                m_wr   = 0;
                m_spec = m_spec && !resolved && !flush;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] s, input bit f, input bit r);
        req_valid = v;
        req_spec  = s;
        flush     = f;
        resolved  = r;
    endtask

    bit           pend   [N];
    bit           pspec  [N];
    logic [SW-1:0] psel  [N];
    int           n2;

    initial begin
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_rr = 0; m_wr = 0; m_spec = 0; m_sel = 0; m_src = 0;
        rst = 1'b1;
        drive(3'b111, 3'b000, 1'b0, 1'b0);
        req_sel = '0;
        req_sel[0*SW +: SW] = 5'd3;
        req_sel[1*SW +: SW] = 5'd5;
        req_sel[2*SW +: SW] = 5'd9;
        @(posedge CLK);
        #1;

        // Reset held two cycles with everyone requesting
        run_cycle(0, 0);
        run_cycle(0, 0);
        check("rst_wb_sel", 32'(wb_sel), 0);
        rst = 1'b0;
        run_cycle(3'b001, 0);

        // Fixed priority
        drive(3'b110, 3'b000, 1'b0, 1'b0);
        run_cycle(3'b010, 1);
        check("prio_sel1", 32'(wb_sel), 5);
        check("prio_src1", 32'(wb_src), 1);
        drive(3'b100, 3'b000, 1'b0, 1'b0);
        run_cycle(3'b100, 1);
        check("prio_sel2", 32'(wb_sel), 9);
        check("prio_wr2", 32'(wb_write), 1);

        // Aging: req2 promoted past a continuously re-asserting req0
        drive(3'b000, 3'b000, 1'b0, 1'b0);
        run_cycle(0, 1);
        n2 = 0;
        for (int c = 0; c < SMAX + 1; c++) begin
            drive(3'b101, 3'b000, 1'b0, 1'b0);
            req_sel[0*SW +: SW] = 5'($urandom_range(0, 31));
            run_cycle(c == SMAX ? 3'b100 : 3'b001, -1);
            n2 += int'(last_ready[2]);
        end
        check("aging_req2_once", n2, 1);

        // Two starved requesters served round-robin from pointer 0
        drive(3'b000, 3'b000, 1'b0, 1'b0);
        run_cycle(0, -1);
        for (int c = 0; c < SMAX; c++) begin
            drive(3'b111, 3'b000, 1'b0, 1'b0);
            run_cycle(3'b001, -1);
        end
        drive(3'b111, 3'b000, 1'b0, 1'b0);
        run_cycle(3'b010, -1);
        drive(3'b101, 3'b000, 1'b0, 1'b0);
        run_cycle(3'b100, -1);
        check("starve_src2", 32'(wb_src), 2);

        // Flush masks speculative requester and squashes a speculative writeback
        drive(3'b000, 3'b000, 1'b0, 1'b0);
        run_cycle(0, -1);
        drive(3'b001, 3'b001, 1'b0, 1'b0);
        run_cycle(3'b001, -1);
        check("spec_wb", 32'(wb_spec), 1);
        drive(3'b011, 3'b001, 1'b1, 1'b0);
        run_cycle(3'b010, 0);

        // Resolved clears spec tag; flush+resolved behaves as flush
        drive(3'b001, 3'b001, 1'b0, 1'b1);
        run_cycle(3'b001, 1);
        check("resolved_spec", 32'(wb_spec), 0);
        drive(3'b001, 3'b001, 1'b0, 1'b0);
        run_cycle(3'b001, 1);
        drive(3'b000, 3'b000, 1'b1, 1'b1);
        run_cycle(0, 0);

        // Randomized traffic honouring the hold-until-consumed protocol
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3) != 0) begin
                    pend[i]  = 1;
                    pspec[i] = ($urandom % 2) == 1;
                    psel[i]  = 5'($urandom_range(0, 31));
                end
                req_valid[i]         = pend[i];
                req_spec[i]          = pspec[i] & pend[i];
                req_sel[i*SW +: SW]  = psel[i];
            end
            flush    = ($urandom % 8) == 0;
            resolved = ($urandom % 4) == 0;
            rst      = ($urandom % 64) == 0;
            run_cycle(-1, -1);
            for (int i = 0; i < N; i++) begin
                if (last_ready[i]) pend[i] = 0;
                else if (flush && pspec[i]) pend[i] = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
